// File: rtl/exp_controller.sv
// exp_controller: sequencing FSM for the iterative exponential-series datapath.
// Walks the datapath through square, multiply, accumulate and check steps
// until the datapath reports series termination. A watchdog aborts after
// MAX_ITER iterations and raises a sticky error flag.
module exp_controller #(
   parameter int MAX_ITER = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       c_,
   output logic       T_load,
   output logic       T_custom_reset,
   output logic       C_inc,
   output logic       C_reset,
   output logic       X2_load,
   output logic       E_load,
   output logic       E_reset,
   output logic       distance_load,
   output logic       done_set,
   output logic       done_reset,
   output logic [1:0] select_for_mult,
   output logic       hard_reset,
   output logic       busy,
   output logic       err
);

   localparam int IW = $clog2(MAX_ITER + 1);
   localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

   localparam logic [3:0] IDLE   = 4'd0;
   localparam logic [3:0] INIT   = 4'd1;
   localparam logic [3:0] SQ     = 4'd2;
   localparam logic [3:0] MULX2  = 4'd3;
   localparam logic [3:0] MULROM = 4'd4;
   localparam logic [3:0] ACC    = 4'd5;
   localparam logic [3:0] CHECK  = 4'd6;
   localparam logic [3:0] OUT    = 4'd7;
   localparam logic [3:0] FIN    = 4'd8;

   localparam logic [1:0] SEL_XX   = 2'b00;
   localparam logic [1:0] SEL_ROMT = 2'b01;
   localparam logic [1:0] SEL_X2T  = 2'b10;
   localparam logic [1:0] SEL_VE   = 2'b11;

   logic [3:0]    state;
   logic [3:0]    state_nxt;
   logic [IW-1:0] iter;
   logic          err_q;
   logic          iter_at_max;
   logic          launch;

   assign iter_at_max = (iter == ITER_MAX);
   assign launch      = (state == IDLE) && start;

   // Next-state selection; c_ is only consulted in CHECK and start only in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? INIT : IDLE;
         INIT:    state_nxt = SQ;
         SQ:      state_nxt = MULX2;
         MULX2:   state_nxt = MULROM;
         MULROM:  state_nxt = ACC;
         ACC:     state_nxt = CHECK;
         CHECK: begin
            if (c_)
               state_nxt = OUT;
            else if (iter_at_max)
               state_nxt = IDLE;
            else
               state_nxt = MULX2;
         end
         OUT:     state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register with synchronous reset overriding any pending start.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Iteration counter: cleared on launch, saturating increment in ACC.
   always_ff @(posedge clk) begin
      if (reset)
         iter <= '0;
      else if (launch || state == INIT)
         iter <= '0;
      else if (state == ACC && !iter_at_max)
         iter <= iter + IW'(1);
   end

   // Sticky watchdog flag; cleared on the edge entering INIT so INIT already reads 0.
   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (launch)
         err_q <= 1'b0;
      else if (state == CHECK && !c_ && iter_at_max)
         err_q <= 1'b1;
   end

   // Moore output decode: every strobe defaults low, select defaults to x*x.
   always_comb begin
      T_load          = 1'b0;
      T_custom_reset  = 1'b0;
      C_inc           = 1'b0;
      C_reset         = 1'b0;
      X2_load         = 1'b0;
      E_load          = 1'b0;
      E_reset         = 1'b0;
      distance_load   = 1'b0;
      done_set        = 1'b0;
      done_reset      = 1'b0;
      select_for_mult = SEL_XX;
      busy            = (state != IDLE);
      case (state)
         INIT: begin
            C_reset        = 1'b1;
            E_reset        = 1'b1;
            T_custom_reset = 1'b1;
            done_reset     = 1'b1;
         end
         SQ: begin
            select_for_mult = SEL_XX;
            X2_load         = 1'b1;
         end
         MULX2: begin
            select_for_mult = SEL_X2T;
            T_load          = 1'b1;
         end
         MULROM: begin
            select_for_mult = SEL_ROMT;
            T_load          = 1'b1;
         end
         ACC: begin
            E_load = 1'b1;
            C_inc  = 1'b1;
         end
         OUT: begin
            select_for_mult = SEL_VE;
            distance_load   = 1'b1;
         end
         FIN: begin
            done_set = 1'b1;
         end
         default: ;
      endcase
   end

   assign hard_reset = reset;
   assign err        = err_q;

endmodule

// File: doc/exp_controller.md
EXP_CONTROLLER -- requirements
Module: exp_controller

Interface
REQ-001 Parameter MAX_ITER, default 8; maximum series iterations before watchdog abort.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  request a computation; sampled only in IDLE.
REQ-005 Port c_  input  1  datapath counter break flag (series terminated).
REQ-006 Port T_load, T_custom_reset, C_inc, C_reset, X2_load, E_load, E_reset, distance_load, done_set, done_reset  output  1 each  datapath strobes.
REQ-007 Port select_for_mult  output  2  multiplier mux select (00 x*x, 01 rom*T, 10 x2*T, 11 v*E).
REQ-008 Port hard_reset  output  1  datapath Done register reset.
REQ-009 Port busy  output  1  computation in progress.
REQ-010 Port err  output  1  sticky watchdog abort flag.

Function
REQ-011 FSM states SHALL be IDLE, INIT, SQ, MULX2, MULROM, ACC, CHECK, OUT, FIN; all outputs Moore-decoded from state plus err register.
REQ-012 Unlisted strobes SHALL be 0 in every state; select_for_mult SHALL be 00 where not listed.
REQ-013 IDLE: no strobes; start=1 -> INIT, else stay.
REQ-014 INIT: C_reset, E_reset, T_custom_reset, done_reset = 1; iteration counter cleared; err cleared; -> SQ.
REQ-015 SQ: select 00, X2_load=1; -> MULX2.
REQ-016 MULX2: select 10, T_load=1; -> MULROM.
REQ-017 MULROM: select 01, T_load=1; -> ACC.
REQ-018 ACC: E_load=1, C_inc=1; iteration counter +1 (saturating at MAX_ITER); -> CHECK.
REQ-019 CHECK: c_=1 -> OUT; c_=0 and iter<MAX_ITER -> MULX2; c_=0 and iter==MAX_ITER -> IDLE with err set.
REQ-020 c_ SHALL be evaluated only in CHECK; c_ in any other state SHALL be ignored.
REQ-021 OUT: select 11, distance_load=1; -> FIN.
REQ-022 FIN: done_set=1; -> IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 start asserted while busy SHALL be ignored (not queued).
REQ-025 Iteration counter width SHALL be clog2(MAX_ITER+1) bits; no wrap.
REQ-026 Timing: start sampled at edge k -> INIT cycle k+1, SQ k+2, iteration i (0-based) MULX2 at k+3+4i, OUT at k+3+4N, FIN at k+4+4N, busy low from k+5+4N (N = iterations to c_).
REQ-027 Watchdog abort SHALL NOT assert distance_load or done_set.
REQ-028 err SHALL stay 1 until the next INIT or reset.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, iteration counter 0, err 0, regardless of state or start.
REQ-030 hard_reset SHALL equal reset combinationally; all other outputs 0 while state is IDLE after reset.
REQ-031 Reset mid-computation SHALL abort without distance_load or done_set; start in the same cycle as reset SHALL be ignored.

Verification
REQ-032 After reset, start pulse, c_ model asserting after 3 ACCs -> strobe sequence INIT,SQ,(MULX2,MULROM,ACC,CHECK)x3,OUT,FIN; busy high 16 cycles; done_set once at cycle k+16.
REQ-033 c_ held 0, MAX_ITER=8 -> exactly 8 C_inc pulses, return to IDLE, err=1, no distance_load/done_set; next start clears err in INIT.
REQ-034 start pulsed during MULROM and during FIN -> ignored; single computation; start held in IDLE after FIN -> new INIT next cycle.
REQ-035 reset asserted in ACC of iteration 2 -> next cycle IDLE, all strobes 0, hard_reset=1 during reset, busy=0.
REQ-036 c_=1 forced during MULX2/MULROM/ACC only, 0 in CHECK -> loop continues (c_ ignored outside CHECK).
REQ-037 Every cycle: select_for_mult matches REQ-015..REQ-021 whenever X2_load, T_load or distance_load is 1.
